// File: rtl/wb_writeback_unit.sv
// RV32I writeback stage: selects ALU/load/link result and drives the regfile write port.
// Optional `WB_INSTRET_EN adds a 64-bit retired-instruction counter on instret_o.
module wb_writeback_unit #(
    parameter int unsigned     XLEN    = 32,
    parameter logic [XLEN-1:0] RST_PC4 = '0
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic            mem_reg_write_i,
    input  logic [4:0]      mem_rd_addr_i,
    input  logic [1:0]      mem_wb_sel_i,
    input  logic [XLEN-1:0] mem_alu_result_i,
    input  logic [XLEN-1:0] mem_pc_plus4_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            RegWrite_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            wb_busy_o
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret_o
`endif
);

    typedef enum logic {S_IDLE, S_WAIT_LOAD} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_we;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_data;
    logic              w_we_nxt;
    logic [4:0]        w_rd_nxt;
    logic [XLEN-1:0]   w_data_nxt;
    logic              w_done;
    logic              w_xfer;
    logic              w_is_load;
    logic [XLEN-1:0]   w_sel_data;
    logic [XLEN-1:0]   w_load_data;
    logic              r_ld_we;
    logic [4:0]        r_ld_rd;
    logic [2:0]        r_ld_f3;
    logic [1:0]        r_ld_off;

    function automatic logic [XLEN-1:0] align_load(
        input logic [XLEN-1:0] w,
        input logic [2:0]      f3,
        input logic [1:0]      o
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (o)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  align_load = {{24{b[7]}}, b};
            3'b100:  align_load = {24'd0, b};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b101:  align_load = {16'd0, h};
            default: align_load = w;
        endcase
    endfunction

    assign mem_ready_o = (r_state != S_WAIT_LOAD);
    assign wb_busy_o   = (r_state == S_WAIT_LOAD);
    assign w_xfer      = mem_valid_i && mem_ready_o;
    assign w_is_load   = (mem_wb_sel_i == 2'b01);
    assign w_sel_data  = (mem_wb_sel_i == 2'b10) ? mem_pc_plus4_i
                                                 : mem_alu_result_i;
    assign w_load_data = align_load(dmem_rdata_i, r_ld_f3, r_ld_off);

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = 1'b0;
        w_rd_nxt    = r_rd;
        w_data_nxt  = r_data;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && w_is_load) begin
                    w_state_nxt = S_WAIT_LOAD;
                end else if (w_xfer) begin
                    w_we_nxt   = mem_reg_write_i && (mem_rd_addr_i != 5'd0);
                    w_rd_nxt   = mem_rd_addr_i;
                    w_data_nxt = w_sel_data;
                    w_done     = 1'b1;
                end
            end
            default: begin
                if (dmem_rvalid_i) begin
                    w_state_nxt = S_IDLE;
                    w_we_nxt    = r_ld_we && (r_ld_rd != 5'd0);
                    w_rd_nxt    = r_ld_rd;
                    w_data_nxt  = w_load_data;
                    w_done      = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_rd    <= 5'd0;
            r_data  <= RST_PC4;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_rd    <= w_rd_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Load context captured at acceptance; MEM moves on while we wait.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_we  <= 1'b0;
            r_ld_rd  <= 5'd0;
            r_ld_f3  <= 3'd0;
            r_ld_off <= 2'd0;
        end else if (w_xfer && w_is_load) begin
            r_ld_we  <= mem_reg_write_i;
            r_ld_rd  <= mem_rd_addr_i;
            r_ld_f3  <= mem_funct3_i;
            r_ld_off <= mem_alu_result_i[1:0];
        end
    end

    assign RegWrite_o = r_we;
    assign rd_addr_o  = r_rd;
    assign rd_data_o  = r_data;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 64'd0;
        end else if (w_done) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret_o = r_instret;
`else
    logic w_unused_done;
    assign w_unused_done = w_done;
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed table-driven bench for wb_writeback_unit.
// Build with +define+WB_INSTRET_EN to also cover the retired-instruction counter.
module tb_wb_writeback_unit;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic        mem_ready_o;
    logic        mem_reg_write_i = 1'b0;
    logic [4:0]  mem_rd_addr_i = '0;
    logic [1:0]  mem_wb_sel_i = '0;
    logic [31:0] mem_alu_result_i = '0;
    logic [31:0] mem_pc_plus4_i = '0;
    logic [2:0]  mem_funct3_i = '0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        RegWrite_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        wb_busy_o;
`ifdef WB_INSTRET_EN
    logic [63:0] instret_o;
`endif

    int checks = 0;
    int errors = 0;

    wb_writeback_unit #(.XLEN(32), .RST_PC4(32'h0)) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .mem_valid_i(mem_valid_i),
        .mem_ready_o(mem_ready_o),
        .mem_reg_write_i(mem_reg_write_i),
        .mem_rd_addr_i(mem_rd_addr_i),
        .mem_wb_sel_i(mem_wb_sel_i),
        .mem_alu_result_i(mem_alu_result_i),
        .mem_pc_plus4_i(mem_pc_plus4_i),
        .mem_funct3_i(mem_funct3_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i),
        .RegWrite_o(RegWrite_o),
        .rd_addr_o(rd_addr_o),
        .rd_data_o(rd_data_o),
        .wb_busy_o(wb_busy_o)
`ifdef WB_INSTRET_EN
        ,
        .instret_o(instret_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  sel;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  f3;
        int          lat;
        logic [31:0] rdata;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(
        input logic [1:0] sel, input logic rw, input logic [4:0] rd,
        input logic [31:0] alu, input logic [31:0] pc4,
        input logic [2:0] f3, input int lat, input logic [31:0] rdata,
        input logic e_we, input logic [31:0] e_data
    );
        vec_t v;
        v.sel = sel; v.rw = rw; v.rd = rd; v.alu = alu; v.pc4 = pc4;
        v.f3 = f3; v.lat = lat; v.rdata = rdata;
        v.e_we = e_we; v.e_rd = rd; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        chk({tag, ".ready_in"}, 64'(mem_ready_o), 64'd1);
        mem_valid_i      = 1'b1;
        mem_wb_sel_i     = v.sel;
        mem_reg_write_i  = v.rw;
        mem_rd_addr_i    = v.rd;
        mem_alu_result_i = v.alu;
        mem_pc_plus4_i   = v.pc4;
        mem_funct3_i     = v.f3;
        tick();
        mem_valid_i = 1'b0;
        if (v.sel == 2'b01) begin
            for (int i = 0; i < v.lat; i++) begin
                chk({tag, ".wait_ready"}, 64'(mem_ready_o), 64'd0);
                chk({tag, ".wait_busy"}, 64'(wb_busy_o), 64'd1);
                chk({tag, ".wait_we"}, 64'(RegWrite_o), 64'd0);
                if (i == v.lat - 1) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = v.rdata;
                end
                tick();
            end
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = 32'h5A5A_5A5A;
        end
        chk({tag, ".we"}, 64'(RegWrite_o), 64'(v.e_we));
        chk({tag, ".rd"}, 64'(rd_addr_o), 64'(v.e_rd));
        chk({tag, ".data"}, 64'(rd_data_o), 64'(v.e_data));
        chk({tag, ".busy"}, 64'(wb_busy_o), 64'd0);
        tick();
        chk({tag, ".we_pulse"}, 64'(RegWrite_o), 64'd0);
        chk({tag, ".data_hold"}, 64'(rd_data_o), 64'(v.e_data));
    endtask

    initial begin
        tbl[0]  = mk(2'b00, 1, 5'd5,  32'h12,        32'h0,   3'b000, 0, 32'h0,        1, 32'h12);
        tbl[1]  = mk(2'b01, 1, 5'd7,  32'h1003,      32'h0,   3'b000, 3, 32'h80FF_FF00, 1, 32'hFFFF_FF80);
        tbl[2]  = mk(2'b01, 1, 5'd8,  32'h2003,      32'h0,   3'b100, 1, 32'h8001_7F02, 1, 32'h0000_0080);
        tbl[3]  = mk(2'b01, 1, 5'd9,  32'h2002,      32'h0,   3'b001, 2, 32'h8001_7F02, 1, 32'hFFFF_8001);
        tbl[4]  = mk(2'b01, 1, 5'd10, 32'h2000,      32'h0,   3'b101, 1, 32'h8001_7F02, 1, 32'h0000_7F02);
        tbl[5]  = mk(2'b01, 1, 5'd11, 32'h2001,      32'h0,   3'b010, 1, 32'h8001_7F02, 1, 32'h8001_7F02);
        tbl[6]  = mk(2'b10, 1, 5'd0,  32'hAAAA,      32'h200, 3'b000, 0, 32'h0,        0, 32'h200);
        tbl[7]  = mk(2'b10, 1, 5'd1,  32'hBBBB,      32'h104, 3'b000, 0, 32'h0,        1, 32'h104);
        tbl[8]  = mk(2'b11, 1, 5'd12, 32'hDEAD_BEEF, 32'h300, 3'b000, 0, 32'h0,        1, 32'hDEAD_BEEF);
        tbl[9]  = mk(2'b00, 0, 5'd13, 32'h1234_5678, 32'h0,   3'b000, 0, 32'h0,        0, 32'h1234_5678);
        tbl[10] = mk(2'b01, 0, 5'd14, 32'h0001,      32'h0,   3'b100, 2, 32'h8001_7F02, 0, 32'h0000_007F);
        tbl[11] = mk(2'b01, 1, 5'd15, 32'h0003,      32'h0,   3'b001, 1, 32'h8001_7F02, 1, 32'hFFFF_8001);
        tbl[12] = mk(2'b01, 1, 5'd16, 32'h0002,      32'h0,   3'b011, 1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        tbl[13] = mk(2'b01, 1, 5'd0,  32'h0000,      32'h0,   3'b000, 1, 32'h0000_00F0, 0, 32'hFFFF_FFF0);

        #12;
        chk("rst.we", 64'(RegWrite_o), 64'd0);
        chk("rst.rd", 64'(rd_addr_o), 64'd0);
        chk("rst.data", 64'(rd_data_o), 64'd0);
        chk("rst.ready", 64'(mem_ready_o), 64'd1);
        chk("rst.busy", 64'(wb_busy_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // Stray response while idle must not write
        dmem_rvalid_i = 1'b1;
        tick();
        dmem_rvalid_i = 1'b0;
        chk("stray.we", 64'(RegWrite_o), 64'd0);
        chk("stray.busy", 64'(wb_busy_o), 64'd0);

        for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

        // Back-to-back ALU writes
        mem_valid_i = 1'b1; mem_wb_sel_i = 2'b00; mem_reg_write_i = 1'b1;
        mem_rd_addr_i = 5'd5; mem_alu_result_i = 32'h12;
        tick();
        mem_rd_addr_i = 5'd6; mem_alu_result_i = 32'h34;
        chk("b2b.we0", 64'(RegWrite_o), 64'd1);
        chk("b2b.rd0", 64'(rd_addr_o), 64'd5);
        chk("b2b.d0", 64'(rd_data_o), 64'h12);
        chk("b2b.ready", 64'(mem_ready_o), 64'd1);
        tick();
        mem_valid_i = 1'b0;
        chk("b2b.we1", 64'(RegWrite_o), 64'd1);
        chk("b2b.rd1", 64'(rd_addr_o), 64'd6);
        chk("b2b.d1", 64'(rd_data_o), 64'h34);
        tick();
        chk("b2b.end", 64'(RegWrite_o), 64'd0);

        // Reset in the middle of a load, then a late response
        mem_valid_i = 1'b1; mem_wb_sel_i = 2'b01; mem_rd_addr_i = 5'd20;
        mem_funct3_i = 3'b010; mem_alu_result_i = 32'h0;
        tick();
        mem_valid_i = 1'b0;
        chk("mid.busy", 64'(wb_busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.rst_ready", 64'(mem_ready_o), 64'd1);
        chk("mid.rst_data", 64'(rd_data_o), 64'd0);
        chk("mid.rst_rd", 64'(rd_addr_o), 64'd0);
        tick();
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
        tick();
        dmem_rvalid_i = 1'b0;
        chk("mid.we", 64'(RegWrite_o), 64'd0);
        chk("mid.data", 64'(rd_data_o), 64'd0);
        chk("mid.ready", 64'(mem_ready_o), 64'd1);
        chk("mid.busy2", 64'(wb_busy_o), 64'd0);

`ifdef WB_INSTRET_EN
        chk("instret.rst", instret_o, 64'd0);
        run_vec(tbl[0], 100);
        run_vec(tbl[1], 101);
        run_vec(tbl[6], 102);
        run_vec(tbl[7], 103);
        run_vec(tbl[9], 104);
        chk("instret.five", instret_o, 64'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_writeback_unit.md
Name: wb_writeback_unit

Overview:
Writeback stage of the RV32I pipeline and the write-side driver of the 32x32 register file. It accepts one retiring instruction per cycle from the MEM stage and selects the result: ALU result, aligned and extended load data, or PC+4. It drives the register file's write-enable, rd index and rd data. For loads it waits for a variable-latency data-memory response and back-pressures MEM until the response arrives.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RST_PC4, 0, value rd_data_o takes at reset.

Ports:
clk_i  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mem_valid_i  in  1  MEM presents an instruction this cycle
mem_ready_o  out  1  unit accepts an instruction this cycle
mem_reg_write_i  in  1  instruction writes rd
mem_rd_addr_i  in  5  destination register index
mem_wb_sel_i  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
mem_alu_result_i  in  32  ALU result; its low 2 bits are the load byte offset
mem_pc_plus4_i  in  32  link value for JAL/JALR
mem_funct3_i  in  3  load size/sign
dmem_rvalid_i  in  1  data-memory read response valid
dmem_rdata_i  in  32  data-memory read word
RegWrite_o  out  1  register-file write enable
rd_addr_o  out  5  register-file write index
rd_data_o  out  32  register-file write data
wb_busy_o  out  1  load pending (to hazard unit)

Behaviour:
- Reset, rst_n low (asynchronous): state=IDLE; RegWrite_o=0; rd_addr_o=0; rd_data_o=RST_PC4; any pending load is discarded.
- Handshake: an instruction transfers on a rising edge where mem_valid_i && mem_ready_o. mem_ready_o = (state != WAIT_LOAD). It is combinational from state only, with no path from mem_valid_i.
- All three register-file outputs are registered. RegWrite_o is high for exactly one cycle per writing instruction. The register file commits on the following edge.
- States:
  - IDLE/RUN: on a transfer with wb_sel != 01, the next edge sets RegWrite_o = mem_reg_write_i && (rd != 0), rd_addr_o = rd, rd_data_o = the selected value. State stays IDLE/RUN, giving back-to-back throughput of 1 per cycle.
  - On a transfer with wb_sel == 01, the unit latches rd, reg_write, funct3 and offset, sets RegWrite_o=0 and goes to WAIT_LOAD.
  - With no transfer, RegWrite_o=0. rd_addr_o and rd_data_o hold their values.
  - WAIT_LOAD: RegWrite_o=0 and wb_busy_o=1. On an edge with dmem_rvalid_i=1, the unit registers the aligned data, sets RegWrite_o = latched reg_write && (rd != 0), and returns to IDLE. A new instruction can be accepted in the next cycle.
- Load alignment uses the latched offset o[1:0]:
  - LB (000) / LBU (100): byte o, sign- or zero-extended.
  - LH (001) / LHU (101): halfword o[1]; o[0] is ignored.
  - LW (010), and reserved codes 011/110/111: the full word; o is ignored.
- A write to x0 is never signalled: RegWrite_o=0. rd_addr_o and rd_data_o still update.
- dmem_rvalid_i is ignored outside WAIT_LOAD. This covers a stray response after a mid-load reset.
- A load with reg_write=0 still waits for its response and produces no write.
- wb_busy_o = (state == WAIT_LOAD).

Optional Feature:
WB_INSTRET_EN.
- Defined: adds output port instret_o (64 bits). It is reset to 0 and increments by 1 on each instruction completion: a non-load transfer, or a load's rvalid edge, whether or not it writes. It wraps at 2^64-1 to 0.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT_LOAD, then apply rvalid after release -> RegWrite_o=0, state IDLE, mem_ready_o=1, no write.
- Back-to-back ALU: addi x5=0x12, x6=0x34 on consecutive cycles -> RegWrite_o high for 2 consecutive cycles, with rd/data (5,0x12) then (6,0x34).
- Load latency 3: LB rd=7, offset 3, rdata 0x80FF_FF00 -> mem_ready_o low for 3 cycles; then one write of x7=0xFFFF_FF80.
- Load variants on rdata 0x8001_7F02:
  - LBU offset 3 -> 0x0000_0080.
  - LH offset 2 -> 0xFFFF_8001.
  - LHU offset 0 -> 0x0000_7F02.
  - LW -> 0x8001_7F02.
- x0/link: JAL rd=0 -> RegWrite_o=0. JAL rd=1, PC+4=0x104 -> x1=0x104.
- WB_INSTRET_EN: 5 instructions including 1 load and 1 rd=x0 -> instret_o=5.
